// File: rtl/watch_set_ctrl.sv
// Time-setting controller: debounces set/next/up buttons, edits a shadow copy
// of HH:MM:SS in BCD, and strobes the edited value back into the live counters.
module watch_set_ctrl #(
    parameter int DEBOUNCE   = 20,
    parameter int BLINK_HALF = 250,
    parameter int TIMEOUT    = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       set_btn,
    input  logic       next_btn,
    input  logic       up_btn,
    input  logic [3:0] cur_h_ten,
    input  logic [3:0] cur_h_one,
    input  logic [3:0] cur_m_ten,
    input  logic [3:0] cur_m_one,
    input  logic [3:0] cur_s_ten,
    input  logic [3:0] cur_s_one,
    output logic       editing,
    output logic [1:0] field,
    output logic [5:0] blank_mask,
    output logic       load,
    output logic [3:0] ld_h_ten,
    output logic [3:0] ld_h_one,
    output logic [3:0] ld_m_ten,
    output logic [3:0] ld_m_one,
    output logic [3:0] ld_s_ten,
    output logic [3:0] ld_s_one
);

    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int BW  = $clog2(BLINK_HALF + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE - 1);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Button bit order: 0 = set, 1 = next, 2 = up
    logic [2:0]     raw;
    logic [2:0]     sync1;
    logic [2:0]     sync2;
    logic [2:0]     filt;
    logic [2:0]     filt_d;
    logic [2:0]     ev;
    logic [DBW-1:0] db_cnt [3];

    assign raw = {up_btn, next_btn, set_btn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_d <= '0;
            ev     <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            filt_d <= filt;
            ev     <= filt & ~filt_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        filt[i]   <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    logic set_ev;
    logic next_ev;
    logic up_ev;

    assign set_ev  = ev[0];
    assign next_ev = ev[1];
    assign up_ev   = ev[2];

    state_t        state;
    state_t        state_n;
    logic [1:0]    field_n;
    logic [3:0]    h_ten_n;
    logic [3:0]    h_one_n;
    logic [3:0]    m_ten_n;
    logic [3:0]    m_one_n;
    logic [3:0]    s_ten_n;
    logic [3:0]    s_one_n;
    logic [TW-1:0] tmo;
    logic [TW-1:0] tmo_n;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_n;
    logic          blink_off;
    logic          blink_off_n;
    logic          blink_restart;
    logic          editing_n;
    logic          load_n;
    logic [5:0]    blank_n;

    // The if/else chain in EDIT fixes the priority: en drop, then set, next, up
    always_comb begin
        state_n       = state;
        field_n       = field;
        h_ten_n       = ld_h_ten;
        h_one_n       = ld_h_one;
        m_ten_n       = ld_m_ten;
        m_one_n       = ld_m_one;
        s_ten_n       = ld_s_ten;
        s_one_n       = ld_s_one;
        tmo_n         = tmo;
        blink_cnt_n   = blink_cnt;
        blink_off_n   = blink_off;
        blink_restart = 1'b0;

        case (state)
            IDLE: begin
                tmo_n = '0;
                if (en && set_ev) begin
                    h_ten_n = cur_h_ten;
                    h_one_n = cur_h_one;
                    m_ten_n = cur_m_ten;
                    m_one_n = cur_m_one;
                    s_ten_n = cur_s_ten;
                    s_one_n = cur_s_one;
                    field_n = 2'd0;
                    state_n = EDIT;
                end
            end
            EDIT: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (set_ev) begin
                    state_n = COMMIT;
                end else if (next_ev) begin
                    field_n       = (field == 2'd2) ? 2'd0 : field + 2'd1;
                    tmo_n         = '0;
                    blink_restart = 1'b1;
                end else if (up_ev) begin
                    tmo_n = '0;
                    case (field)
                        2'd0: begin
                            if (ld_h_ten == 4'd2 && ld_h_one == 4'd3) begin
                                h_ten_n = 4'd0;
                                h_one_n = 4'd0;
                            end else if (ld_h_one == 4'd9) begin
                                h_one_n = 4'd0;
                                h_ten_n = ld_h_ten + 4'd1;
                            end else begin
                                h_one_n = ld_h_one + 4'd1;
                            end
                        end
                        2'd1: begin
                            if (ld_m_one == 4'd9) begin
                                m_one_n = 4'd0;
                                m_ten_n = (ld_m_ten == 4'd5) ? 4'd0 : ld_m_ten + 4'd1;
                            end else begin
                                m_one_n = ld_m_one + 4'd1;
                            end
                        end
                        2'd2: begin
                            if (ld_s_one == 4'd9) begin
                                s_one_n = 4'd0;
                                s_ten_n = (ld_s_ten == 4'd5) ? 4'd0 : ld_s_ten + 4'd1;
                            end else begin
                                s_one_n = ld_s_one + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end else if (tmo == TMO_LAST) begin
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Blink phase restarts "on" whenever EDIT is entered or the field moves
        if (state_n != EDIT || state != EDIT || blink_restart) begin
            blink_cnt_n = '0;
            blink_off_n = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            blink_off_n = ~blink_off;
        end else begin
            blink_cnt_n = blink_cnt + 1'b1;
        end

        editing_n = (state_n == EDIT);
        load_n    = (state_n == COMMIT);
        blank_n   = 6'b000000;
        if (editing_n && blink_off_n) begin
            case (field_n)
                2'd0:    blank_n = 6'b110000;
                2'd1:    blank_n = 6'b001100;
                2'd2:    blank_n = 6'b000011;
                default: blank_n = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            field      <= 2'd0;
            editing    <= 1'b0;
            load       <= 1'b0;
            blank_mask <= 6'b000000;
            tmo        <= '0;
            blink_cnt  <= '0;
            blink_off  <= 1'b0;
            ld_h_ten   <= 4'd0;
            ld_h_one   <= 4'd0;
            ld_m_ten   <= 4'd0;
            ld_m_one   <= 4'd0;
            ld_s_ten   <= 4'd0;
            ld_s_one   <= 4'd0;
        end else begin
            state      <= state_n;
            field      <= field_n;
            editing    <= editing_n;
            load       <= load_n;
            blank_mask <= blank_n;
            tmo        <= tmo_n;
            blink_cnt  <= blink_cnt_n;
            blink_off  <= blink_off_n;
            ld_h_ten   <= h_ten_n;
            ld_h_one   <= h_one_n;
            ld_m_ten   <= m_ten_n;
            ld_m_one   <= m_one_n;
            ld_s_ten   <= s_ten_n;
            ld_s_one   <= s_one_n;
        end
    end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Time-setting controller for the watch datapath (HH:MM:SS BCD counters at 1 kHz).
- Debounces three push-buttons (set, next, up) and runs an edit FSM that selects the hour, minute or second field.
- Edits a shadow copy of the time, then issues a single-cycle load strobe with the new BCD digits to the counters.
- Drives a blink mask so the 7-segment scanner flashes the field being edited.

Parameters:
- DEBOUNCE, 20, consecutive clk cycles a synchronized button level must hold before the filtered level changes.
- BLINK_HALF, 250, clk cycles per blink half-period (on, then off).
- TIMEOUT, 10000, clk cycles without an accepted press before an edit is aborted.

Ports:
- clk  in  1  1 kHz system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  high when the watch mode is active; low forces an abort.
- set_btn  in  1  raw set button, asynchronous, active-high.
- next_btn  in  1  raw field-advance button, asynchronous, active-high.
- up_btn  in  1  raw increment button, asynchronous, active-high.
- cur_h_ten, cur_h_one, cur_m_ten, cur_m_one, cur_s_ten, cur_s_one  in  4 each  live BCD time from the counters.
- editing  out  1  high while the FSM is in any EDIT state.
- field  out  2  0=hour, 1=min, 2=sec; 3 is never driven.
- blank_mask  out  6  per-digit blank; bit5=h_ten down to bit0=s_one.
- load  out  1  one-cycle strobe telling the counters to take the ld_* values.
- ld_h_ten, ld_h_one, ld_m_ten, ld_m_one, ld_s_ten, ld_s_one  out  4 each  shadow BCD values.

Behaviour:
- Reset (async):
  - state=IDLE; editing=0, field=0, blank_mask=0, load=0, all ld_*=0.
  - Synchronizers, filtered levels, debounce, blink and timeout counters all cleared.
- Button path (per button):
  - 2-FF synchronizer, then debounce counter.
  - The filtered level toggles after DEBOUNCE consecutive cycles in which the synced level differs from the filtered level. Any agreement resets the counter.
  - Press event = registered one-cycle pulse on a filtered 0->1 transition.
  - Releases produce no event. A held button produces exactly one event.
- Latency: the FSM/shadow effect of a clean press is visible on outputs DEBOUNCE+3 clk edges after the first edge sampling the raw high.
- Event priority when events coincide in one cycle: set > next > up. Lower-priority events in that cycle are discarded.
- IDLE:
  - If en=1 and set event: copy all cur_* into the shadow (ld_*), field=0, go to EDIT.
  - Other events are ignored.
- EDIT (editing=1):
  - next event: field 0->1->2->0.
  - up event: increment the selected field in BCD with wrap.
    - Hour: 23 -> 00; one digit 9 -> 0 carries into the ten digit.
    - Min and sec: 59 -> 00.
    - Only the selected field's two digits change.
  - set event: go to COMMIT.
  - en=0 (sampled): abort to IDLE without load. Takes priority over all events.
  - Timeout counter:
    - Clears on entering EDIT and on any accepted event.
    - Reaching TIMEOUT-1 aborts to IDLE without load.
- COMMIT:
  - load=1 for exactly one cycle with the stable shadow values on ld_*.
  - Next state IDLE.
  - ld_* hold their values after commit until the next capture.
- Blink:
  - Counter runs only in EDIT and restarts at 0 with phase=on on entering EDIT and on every field change.
  - During the off phase, blank_mask sets the two bits of the selected field: hour=6'b110000, min=6'b001100, sec=6'b000011.
  - On phase or non-EDIT: blank_mask=0.
- Outputs are registered; field and editing change in the same cycle as the state change.
- Shadow values only change on capture or up events. Live time keeps running during edit; the commit overwrites it.

Test Plan (DEBOUNCE=4, BLINK_HALF=8, TIMEOUT=200):
- Reset mid-edit (rst pulsed asynchronously between clock edges) -> all outputs 0 immediately, state IDLE, no load pulse.
- cur=12:34:56, press set, press up x3, press set -> load pulses exactly 1 cycle with ld=15:34:56; editing=0 the cycle after.
- Edit hour with shadow 23, press up -> 00; next, shadow min 59, up -> 00; next, sec 09, up -> 10. Commit -> 00:00:10.
- Bounce: set_btn toggles every 2 cycles for 20 cycles, then held high -> exactly one set event after the stable run; released and pressed again -> second event.
- Enter EDIT, no presses for 200 cycles -> editing falls to 0, load never asserted; same result when en dropped mid-edit.
- set and up pressed in the same cycle while in EDIT -> COMMIT taken, shadow unchanged. In EDIT hour field, blank_mask alternates 000000/110000 every 8 cycles, and restarts in phase on when next is pressed.
